vga_anim_sequencer: RTL

VGA_ANIM_SEQUENCER -- requirements
Module: vga_anim_sequencer

---
 rtl/vga_anim_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vga_anim_sequencer.sv
// Text animation sequencer: horizontal scroll or vertical bounce with dwell, stepped once per frame tick.
// All outputs are registered; frame_tick lags the vblank sample by one cycle, and animation updates land on the following edge.
module vga_anim_sequencer #(
  parameter int COLS        = 40,
  parameter int TEXT_LEN    = 11,
  parameter int ROW_MIN     = 10,
  parameter int ROW_MAX     = 17,
  parameter int SCROLL_ROW  = 14,
  parameter int HOLD_FRAMES = 60,
  parameter int VBLANK_LINE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       move_mode,
  input  logic [1:0] speed,
  input  logic       pause,
  output logic [5:0] text_col,
  output logic [4:0] text_row,
  output logic [7:0] color_phase,
  output logic       frame_tick,
  output logic [1:0] state
);

  localparam logic [1:0] S_SCROLL    = 2'd0;
  localparam logic [1:0] S_BOUNCE_DN = 2'd1;
  localparam logic [1:0] S_BOUNCE_UP = 2'd2;
  localparam logic [1:0] S_HOLD      = 2'd3;

  localparam logic [5:0] COL_LAST  = 6'(COLS - 1);
  localparam logic [5:0] COL_MID   = 6'((COLS - TEXT_LEN) / 2);
  localparam logic [4:0] ROW_LO    = 5'(ROW_MIN);
  localparam logic [4:0] ROW_HI    = 5'(ROW_MAX);
  localparam logic [4:0] ROW_SCR   = 5'(SCROLL_ROW);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [9:0] VBL_LINE  = 10'(VBLANK_LINE);

  logic [1:0] state_nxt;
  logic [5:0] col_nxt;
  logic [4:0] row_nxt;
  logic [7:0] phase_nxt;
  logic [2:0] div_q, div_nxt;
  logic [7:0] hold_q, hold_nxt;
  logic [2:0] period_m1;
  logic       active, step_en, mode_chg;

  assign active = frame_tick & ~pause;

  always_comb begin
    period_m1 = 3'd0;
    case (speed)
      2'd0:    period_m1 = 3'd7;
      2'd1:    period_m1 = 3'd3;
      2'd2:    period_m1 = 3'd1;
      default: period_m1 = 3'd0;
    endcase
  end

  // >= rather than == so a speed change to a shorter period fires immediately.
  assign step_en  = (div_q >= period_m1);
  assign mode_chg = (state == S_SCROLL) ? move_mode : ~move_mode;

  always_ff @(posedge clk) begin
    if (reset) state <= S_SCROLL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (active) begin
      if (mode_chg) begin
        state_nxt = move_mode ? S_BOUNCE_DN : S_SCROLL;
      end else begin
        case (state)
          S_BOUNCE_DN: if (step_en && text_row == ROW_HI) state_nxt = S_HOLD;
          S_HOLD:      if (hold_q == HOLD_LAST)           state_nxt = S_BOUNCE_UP;
          S_BOUNCE_UP: if (step_en && text_row == ROW_LO) state_nxt = S_BOUNCE_DN;
          default:     state_nxt = state;
        endcase
      end
    end
  end

  always_comb begin
    col_nxt   = text_col;
    row_nxt   = text_row;
    phase_nxt = color_phase;
    div_nxt   = div_q;
    hold_nxt  = hold_q;
    if (active) begin
      phase_nxt = color_phase + 8'd1;
      if (mode_chg) begin
        div_nxt  = 3'd0;
        hold_nxt = 8'd0;
        if (move_mode) begin
          col_nxt = COL_MID;
          row_nxt = ROW_LO;
        end else begin
          col_nxt = COL_LAST;
          row_nxt = ROW_SCR;
        end
      end else begin
        div_nxt = step_en ? 3'd0 : div_q + 3'd1;
        case (state)
          S_SCROLL: begin
            if (step_en) col_nxt = (text_col == 6'd0) ? COL_LAST : text_col - 6'd1;
          end
          S_BOUNCE_DN: begin
            if (step_en && text_row != ROW_HI) row_nxt = text_row + 5'd1;
          end
          S_BOUNCE_UP: begin
            if (step_en && text_row != ROW_LO) row_nxt = text_row - 5'd1;
          end
          default: begin
            // Dwell counts every active tick; leaving it restarts the step cadence.
            if (hold_q == HOLD_LAST) begin
              hold_nxt = 8'd0;
              div_nxt  = 3'd0;
            end else begin
              hold_nxt = hold_q + 8'd1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      text_col    <= COL_LAST;
      text_row    <= ROW_SCR;
      color_phase <= 8'd0;
      frame_tick  <= 1'b0;
      div_q       <= 3'd0;
      hold_q      <= 8'd0;
    end else begin
      text_col    <= col_nxt;
      text_row    <= row_nxt;
      color_phase <= phase_nxt;
      frame_tick  <= (hpos == 10'd0) && (vpos == VBL_LINE);
      div_q       <= div_nxt;
      hold_q      <= hold_nxt;
    end
  end

endmodule
